// File: rtl/control.sv
// Key/note player: latches one byte per accepted UART message onto out and
// holds it for T clock cycles (C_MUSIC ms) before returning to silence.
module control #(
    parameter int C_CLK_FRQ = 100_000_000,
    parameter int C_MUSIC   = 5
) (
    input  logic       clk,
    input  logic       rstb,
    input  logic       UART_valid,
    input  logic       UART_err,
    input  logic [7:0] UART_msg,
    output logic [7:0] out
);

    localparam int T  = (C_CLK_FRQ / 1000) * C_MUSIC;
    localparam int CW = (T > 1) ? $clog2(T) : 1;
    localparam logic [CW-1:0] LAST = CW'(T - 1);

    typedef enum logic {
        IDLE,
        PLAY
    } stateT;

    stateT         state;
    stateT         nextState;
    logic [CW-1:0] count;
    logic [CW-1:0] nextCount;
    logic [7:0]    nextOut;
    logic          validD;
    logic          accept;

    // Only the first high cycle of a valid pulse can be accepted, and only if
    // the receiver flags no error in that same cycle.
    assign accept = UART_valid & ~validD & ~UART_err;

    // State, hold counter, output pattern and the valid edge detector.
    always_ff @(posedge clk) begin
        if (rstb) begin
            state  <= IDLE;
            count  <= '0;
            out    <= 8'h00;
            validD <= 1'b0;
        end else begin
            state  <= nextState;
            count  <= nextCount;
            out    <= nextOut;
            validD <= UART_valid;
        end
    end

    // A new message always wins over expiry of the current interval.
    always_comb begin
        nextState = state;
        nextCount = count;
        nextOut   = out;
        if (accept) begin
            nextCount = '0;
            if (UART_msg != 8'h00) begin
                nextState = PLAY;
                nextOut   = UART_msg;
            end else begin
                nextState = IDLE;
                nextOut   = 8'h00;
            end
        end else if (state == PLAY) begin
            if (count == LAST) begin
                nextState = IDLE;
                nextCount = '0;
                nextOut   = 8'h00;
            end else begin
                nextCount = count + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_control.sv
// Scoreboard bench for control: each driven cycle pushes the expected out
// value for the following edge, which a monitor pops and compares.
module tb_control;

    localparam int CLK_FRQ = 10_000;
    localparam int MUSIC   = 2;
    localparam int T       = (CLK_FRQ / 1000) * MUSIC;

    typedef struct {
        string      tag;
        logic [7:0] value;
    } expT;

    logic       clk;
    logic       rstb;
    logic       UART_valid;
    logic       UART_err;
    logic [7:0] UART_msg;
    logic [7:0] out;

    expT        expQ[$];
    int         testCount;
    int         failCount;

    logic [7:0] expOut;
    int         holdLeft;
    logic       prevValid;

    control #(
        .C_CLK_FRQ(CLK_FRQ),
        .C_MUSIC  (MUSIC)
    ) dut (
        .clk       (clk),
        .rstb      (rstb),
        .UART_valid(UART_valid),
        .UART_err  (UART_err),
        .UART_msg  (UART_msg),
        .out       (out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [7:0] actual, input logic [7:0] expected);
        testCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, actual, expected, $time);
        end
    endtask

    // Drive one cycle of inputs and predict out after the next rising edge,
    // using a count of edges still left in the current hold interval.
    task automatic applyStimulus(input logic rst, input logic valid, input logic err,
                                 input logic [7:0] msg, input string tag);
        expT e;
        @(negedge clk);
        rstb       = rst;
        UART_valid = valid;
        UART_err   = err;
        UART_msg   = msg;
        if (rst) begin
            expOut    = 8'h00;
            holdLeft  = 0;
            prevValid = 1'b0;
        end else begin
            if (valid && !prevValid && !err) begin
                expOut   = msg;
                holdLeft = (msg != 8'h00) ? T - 1 : 0;
            end else if (holdLeft > 0) begin
                holdLeft--;
            end else begin
                expOut = 8'h00;
            end
            prevValid = valid;
        end
        e.tag   = tag;
        e.value = expOut;
        expQ.push_back(e);
    endtask

    task automatic sendMsg(input logic [7:0] msg, input int cycles, input logic err, input string tag);
        for (int i = 0; i < cycles; i++) applyStimulus(1'b0, 1'b1, err, msg, tag);
    endtask

    task automatic idleCycles(input int n, input string tag);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 8'hA5, tag);
    endtask

    always @(posedge clk) begin
        expT e;
        #1;
        if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput(e.tag, out, e.value);
        end
    end

    initial begin
        testCount  = 0;
        failCount  = 0;
        expOut     = 8'h00;
        holdLeft   = 0;
        prevValid  = 1'b0;
        rstb       = 1'b1;
        UART_valid = 1'b0;
        UART_err   = 1'b0;
        UART_msg   = 8'h00;

        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, "reset");
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, "reset");

        sendMsg(8'h7A, 3, 1'b0, "play7A");
        idleCycles(T + 5, "hold7A");

        sendMsg(8'h91, 4, 1'b0, "play91");
        idleCycles(T + 5, "hold91");

        sendMsg(8'h7A, 1, 1'b0, "retrigFirst");
        idleCycles(8, "retrigHold");
        sendMsg(8'h91, 2, 1'b0, "retrigSecond");
        idleCycles(T + 5, "retrigTail");

        sendMsg(8'h55, 1, 1'b1, "errFirst");
        sendMsg(8'h55, 2, 1'b0, "errLater");
        idleCycles(3, "errIdle");

        sendMsg(8'h3C, 1, 1'b0, "play3C");
        idleCycles(4, "hold3C");
        applyStimulus(1'b0, 1'b0, 1'b1, 8'hEE, "errAlone");
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h81, "msgNoValid");
        idleCycles(T, "tail3C");

        sendMsg(8'h7A, 1, 1'b0, "stopPlay");
        idleCycles(4, "stopHold");
        sendMsg(8'h00, 2, 1'b0, "stopZero");
        idleCycles(5, "stopIdle");

        sendMsg(8'hFF, 1, 1'b0, "abortPlay");
        idleCycles(4, "abortHold");
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, "abortReset");
        idleCycles(T + 2, "abortIdle");

        // Second message arrives exactly on the edge where the first expires.
        sendMsg(8'h11, 1, 1'b0, "edgeFirst");
        idleCycles(T - 1, "edgeHold");
        sendMsg(8'h22, 1, 1'b0, "edgeSecond");
        idleCycles(T + 3, "edgeTail");

        applyStimulus(1'b1, 1'b1, 1'b0, 8'h44, "validInReset");
        sendMsg(8'h44, 2, 1'b0, "validAfterReset");
        idleCycles(T + 2, "validAfterTail");

        for (int i = 0; i < 300; i++) begin
            applyStimulus(($urandom_range(0, 49) == 0), ($urandom_range(0, 5) == 0),
                          ($urandom_range(0, 3) == 0), 8'($urandom_range(0, 255)), "random");
        end
        idleCycles(T + 2, "randomTail");

        @(posedge clk);
        #3;
        checkOutput("queueDrained", 8'(expQ.size()), 8'd0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule

// File: doc/control.md
CONTROL -- requirements
Module: control

Interface
REQ-001 Parameter C_CLK_FRQ, default 100_000_000, clock frequency in Hz.
REQ-002 Parameter C_MUSIC, default 5, note/light hold duration in ms.
REQ-003 Derived constant T = (C_CLK_FRQ/1000)*C_MUSIC clock cycles; T = 500_000 at defaults; T >= 1 SHALL hold.
REQ-004 clk  input  1  single system clock, all logic on rising edge.
REQ-005 rstb  input  1  reset, synchronous and active-high.
REQ-006 UART_valid  input  1  message-valid strobe from UART receiver; may stay high several cycles per message.
REQ-007 UART_err  input  1  framing/parity error flag from UART receiver, qualifies UART_valid.
REQ-008 UART_msg  input  8  received byte; bit i = key/note i pressed.
REQ-009 out  output  8  registered key/note drive pattern.

Function
REQ-010 The block SHALL keep registered copy valid_d of UART_valid; accept event = UART_valid & ~valid_d & ~UART_err, evaluated each rising edge.
REQ-011 A valid pulse of any length SHALL produce at most one accept event (its first high cycle only).
REQ-012 If UART_err is high in the first high cycle of UART_valid, the message SHALL be discarded; no later cycle of that same pulse SHALL be accepted.
REQ-013 States: IDLE (out = 0, counter = 0) and PLAY (out = latched byte, counter running).
REQ-014 On accept event with UART_msg != 0x00: out <= UART_msg, counter <= 0, state <= PLAY, in either state.
REQ-015 On accept event with UART_msg == 0x00: out <= 0, counter <= 0, state <= IDLE.
REQ-016 Latency: out SHALL show the new byte from the rising edge at which the accept event is sampled (one edge after UART_valid rises, no extra pipeline).
REQ-017 In PLAY without accept event: counter increments by 1 per cycle; when counter == T-1, next edge SHALL set out <= 0, counter <= 0, state <= IDLE.
REQ-018 Therefore out SHALL hold a byte for exactly T consecutive cycles unless retriggered.
REQ-019 Retrigger in PLAY (accept event) SHALL replace out and restart full T-cycle interval; no OR-merging of bytes.
REQ-020 Accept event on the same edge the counter reaches T-1 SHALL take priority: new byte loaded, counter restarts.
REQ-021 UART_err alone (without valid rising edge) SHALL not affect state, counter or out.
REQ-022 UART_msg SHALL only be sampled on accept-event cycles; changes at other times have no effect.
REQ-023 Counter width SHALL be ceil(log2(T)) bits minimum, unsigned, never wrapping before T-1.

Reset
REQ-024 While rstb = 1 at a rising edge: out <= 0x00, counter <= 0, valid_d <= 0, state <= IDLE; reset overrides any accept event.
REQ-025 Reset asserted mid-PLAY SHALL abort the interval; after release, out stays 0 until a new accept event.
REQ-026 UART_valid already high when reset releases SHALL count as a rising edge (valid_d = 0 after reset).

Verification (defaults: 100 MHz, C_MUSIC = 5, T = 500_000)
REQ-027 Reset, then UART_valid high 3 cycles with UART_msg = 0x7A, UART_err = 0 -> out = 0x7A one edge later for exactly 500_000 cycles (5 ms), then 0x00.
REQ-028 After idle, valid 4 cycles with 0x91 -> out = 0x91 for 5 ms, back to 0x00; only one interval despite multi-cycle valid.
REQ-029 0x7A accepted, 0x91 accepted 2 ms later -> out switches to 0x91 immediately, returns to 0x00 5 ms after the second accept (7 ms after first).
REQ-030 Valid with 0x55 and UART_err = 1 -> out remains 0x00; err pulse without valid during PLAY -> out unchanged.
REQ-031 0x7A accepted, then 0x00 accepted 1 ms later -> out = 0x00 from that edge, state IDLE.
REQ-032 0xFF accepted, rstb = 1 for one cycle 1 ms later -> out = 0x00 at that edge and stays 0x00 with no further valid.
